// File: rtl/issue_ctrl_if.sv
// issue_ctrl_if: fetch-side and decoder-side signals of the issue controller.
//
// Handshake: an instruction moves from fetch into the queue on a rising clk
// edge where if_valid and if_ready are both high. if_ready never depends on
// if_valid. The decoder side is a one-cycle strobe: dec_valid high for one
// enabled cycle means dec_instr/dec_pc/dec_target describe a newly issued
// instruction; the decoder has no ready, the full flags provide back-pressure.
interface issue_ctrl_if;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [1:0]  dec_target;

  // master: fetch / decoder environment side
  modport master (
    output if_valid, if_instr, if_pc,
    input  if_ready,
    input  dec_valid, dec_instr, dec_pc, dec_target
  );

  // slave: the issue controller itself
  modport slave (
    input  if_valid, if_instr, if_pc,
    output if_ready,
    output dec_valid, dec_instr, dec_pc, dec_target
  );
endinterface

// File: rtl/issue_ctrl.sv
// issue_ctrl: in-order issue controller between fetch and decode.
// A circular queue of IQ_DEPTH entries holds fetched {instr, pc}; the head
// entry is classified by opcode into RS / LSB / RoB-only and issued when the
// RoB and the target unit both have room. flush_in discards all queued work.
// Optional feature macro: ISSUE_PERF_EN adds the stall_cycles counter port.
module issue_ctrl #(
  parameter int IQ_DEPTH = 4
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      rdy_in,
  input  logic                      flush_in,
  input  logic                      rob_full,
  input  logic                      rs_full,
  input  logic                      lsb_full,
  issue_ctrl_if.slave               bus,
  output logic [1:0]                stall_reason,
`ifdef ISSUE_PERF_EN
  output logic [15:0]               stall_cycles,
`endif
  output logic [1:0]                dbg_state,
  output logic [$clog2(IQ_DEPTH):0] dbg_count
);

  localparam int PTR_W = $clog2(IQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(IQ_DEPTH);

  localparam logic [1:0] T_NONE = 2'b00;
  localparam logic [1:0] T_RS   = 2'b01;
  localparam logic [1:0] T_LSB  = 2'b10;
  localparam logic [1:0] T_ROB  = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               dec_valid_q, dec_valid_d;
  logic [31:0]        dec_instr_q, dec_instr_d;
  logic [31:0]        dec_pc_q, dec_pc_d;
  logic [1:0]         dec_target_q, dec_target_d;
  logic [1:0]         stall_reason_q, stall_reason_d;

  logic [31:0]        instr_mem_q [IQ_DEPTH];
  logic [31:0]        pc_mem_q    [IQ_DEPTH];

  logic [31:0]        head_instr;
  logic [31:0]        head_pc;
  logic [1:0]         head_target;
  logic               target_full;
  logic               issue_ok;
  logic               enq;
  logic               do_enq;
  logic               if_ready;

  assign head_instr = instr_mem_q[head_q];
  assign head_pc    = pc_mem_q[head_q];

  // if_ready deliberately ignores a same-cycle issue: a full queue refuses
  // fetch even when the head leaves at this edge.
  assign if_ready = rst_n_in && (state_q != ST_FLUSH) && (count_q < DEPTH_C);
  assign enq      = bus.if_valid && if_ready;

  // Classify the head instruction by its major opcode.
  always_comb begin
    head_target = T_ROB;
    unique case (head_instr[6:0])
      7'b0000011, 7'b0100011:                       head_target = T_LSB;
      7'b1100111, 7'b1100011, 7'b0110011, 7'b0010011: head_target = T_RS;
      default:                                      head_target = T_ROB;
    endcase
  end

  // Issue only when the RoB and the head's target unit both have room.
  always_comb begin
    target_full = 1'b0;
    unique case (head_target)
      T_RS:    target_full = rs_full;
      T_LSB:   target_full = lsb_full;
      default: target_full = 1'b0;
    endcase
    issue_ok = (count_q != '0) && !rob_full && !target_full;
  end

  // Next-state: pointers, count, decoder strobe, FSM and stall cause.
  always_comb begin
    state_d        = state_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    dec_valid_d    = 1'b0;
    dec_instr_d    = dec_instr_q;
    dec_pc_d       = dec_pc_q;
    dec_target_d   = T_NONE;
    stall_reason_d = 2'b00;
    do_enq         = 1'b0;

    if (flush_in) begin
      // Flush beats both the enqueue and the issue of this cycle.
      state_d = ST_FLUSH;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      do_enq = enq;
      if (enq) begin
        tail_d = tail_q + PTR_W'(1);
      end
      if (issue_ok) begin
        dec_valid_d  = 1'b1;
        dec_instr_d  = head_instr;
        dec_pc_d     = head_pc;
        dec_target_d = head_target;
        head_d       = head_q + PTR_W'(1);
      end
      unique case ({enq, issue_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if ((count_q != '0) && !issue_ok) begin
        state_d = ST_STALL;
        if (rob_full) begin
          stall_reason_d = 2'b01;
        end else if (head_target == T_LSB) begin
          stall_reason_d = 2'b11;
        end else begin
          stall_reason_d = 2'b10;
        end
      end else begin
        state_d = ST_RUN;
      end
    end
  end

  // Control registers; rdy_in low freezes everything, reset overrides it.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q        <= ST_RUN;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      dec_valid_q    <= 1'b0;
      dec_instr_q    <= '0;
      dec_pc_q       <= '0;
      dec_target_q   <= T_NONE;
      stall_reason_q <= 2'b00;
    end else if (rdy_in) begin
      state_q        <= state_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      dec_valid_q    <= dec_valid_d;
      dec_instr_q    <= dec_instr_d;
      dec_pc_q       <= dec_pc_d;
      dec_target_q   <= dec_target_d;
      stall_reason_q <= stall_reason_d;
    end
  end

  // Queue storage; stale entries need no reset since count gates their use.
  always_ff @(posedge clk_in) begin
    if (rst_n_in && rdy_in && do_enq) begin
      instr_mem_q[tail_q] <= bus.if_instr;
      pc_mem_q[tail_q]    <= bus.if_pc;
    end
  end

`ifdef ISSUE_PERF_EN
  logic [15:0] stall_cycles_q;

  // Count enabled edges that leave the controller stalled; saturating.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      stall_cycles_q <= '0;
    end else if (rdy_in && (state_d == ST_STALL) && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_q <= stall_cycles_q + 16'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
`endif

  assign bus.if_ready   = if_ready;
  assign bus.dec_valid  = dec_valid_q;
  assign bus.dec_instr  = dec_instr_q;
  assign bus.dec_pc     = dec_pc_q;
  assign bus.dec_target = dec_target_q;
  assign stall_reason   = stall_reason_q;
  assign dbg_state      = state_q;
  assign dbg_count      = count_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// tb_issue_ctrl: directed bench for issue_ctrl (IQ_DEPTH = 4).
// Issued instructions are checked against a queue of hand-written
// expectations; timing-sensitive points are checked directly after edges.
module tb_issue_ctrl;

  localparam int DEPTH = 4;

  localparam logic [31:0] I_ADDI = 32'h00100093;
  localparam logic [31:0] I_LW   = 32'h0000A103;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_LUI  = 32'h000012B7;
  localparam logic [31:0] I_JAL  = 32'h0000006F;
  localparam logic [31:0] I_BEQ  = 32'h00000063;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       rdy;
  logic       flush;
  logic       rob_full;
  logic       rs_full;
  logic       lsb_full;
  logic [1:0] stall_reason;
  logic [1:0] dbg_state;
  logic [2:0] dbg_count;
`ifdef ISSUE_PERF_EN
  logic [15:0] stall_cycles;
`endif

  issue_ctrl_if bus ();

  issue_ctrl #(.IQ_DEPTH(DEPTH)) dut (
    .clk_in       (clk),
    .rst_n_in     (rst_n),
    .rdy_in       (rdy),
    .flush_in     (flush),
    .rob_full     (rob_full),
    .rs_full      (rs_full),
    .lsb_full     (lsb_full),
    .bus          (bus),
    .stall_reason (stall_reason),
`ifdef ISSUE_PERF_EN
    .stall_cycles (stall_cycles),
`endif
    .dbg_state    (dbg_state),
    .dbg_count    (dbg_count)
  );

  int checks = 0;
  int errors = 0;

  // scoreboard: {target, pc, instr} of every instruction expected to issue
  logic [65:0] exp_q[$];
  logic        rdy_edge;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_set(input logic [31:0] instr, input logic [31:0] pc);
    bus.if_valid = 1'b1;
    bus.if_instr = instr;
    bus.if_pc    = pc;
  endtask

  task automatic idle();
    bus.if_valid = 1'b0;
  endtask

  task automatic exp_push(input logic [1:0] tgt, input logic [31:0] pc, input logic [31:0] instr);
    exp_q.push_back({tgt, pc, instr});
  endtask

  always @(posedge clk) rdy_edge <= rdy;

  // scoreboard monitor: each enabled edge with dec_valid is a new issue
  always @(negedge clk) begin
    if (rst_n && rdy_edge && bus.dec_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue observed pc=%0h expected no issue", bus.dec_pc);
        $error("unexpected issue");
      end else begin
        logic [65:0] e;
        e = exp_q.pop_front();
        checks++;
        assert ({bus.dec_target, bus.dec_pc, bus.dec_instr} === e) else begin
          errors++;
          $display("FAIL issue observed=%0h expected=%0h", {bus.dec_target, bus.dec_pc, bus.dec_instr}, e);
          $error("issue mismatch");
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; rdy = 1'b1; flush = 1'b0;
    rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
    bus.if_valid = 1'b0; bus.if_instr = '0; bus.if_pc = '0;

    // reset state
    step(); step();
    check("rst_if_ready",   32'(bus.if_ready),   32'd0);
    check("rst_dec_valid",  32'(bus.dec_valid),  32'd0);
    check("rst_dec_instr",  bus.dec_instr,       32'd0);
    check("rst_dec_pc",     bus.dec_pc,          32'd0);
    check("rst_dec_target", 32'(bus.dec_target), 32'd0);
    check("rst_stall",      32'(stall_reason),   32'd0);
    check("rst_count",      32'(dbg_count),      32'd0);
    check("rst_state",      32'(dbg_state),      32'd0);
`ifdef ISSUE_PERF_EN
    check("rst_perf",       32'(stall_cycles),   32'd0);
`endif
    rst_n = 1'b1;
    #1;
    check("post_rst_if_ready", 32'(bus.if_ready), 32'd1);

    // stream addi then lw: one-cycle latency, back-to-back issue
    push_set(I_ADDI, 32'h0); exp_push(2'b01, 32'h0, I_ADDI);
    step();
    check("lat_not_yet", 32'(bus.dec_valid), 32'd0);
    push_set(I_LW, 32'h4); exp_push(2'b10, 32'h4, I_LW);
    step();
    check("s1_valid",  32'(bus.dec_valid),  32'd1);
    check("s1_pc",     bus.dec_pc,          32'h0);
    check("s1_target", 32'(bus.dec_target), 32'd1);
    idle();
    step();
    check("s2_valid",  32'(bus.dec_valid),  32'd1);
    check("s2_pc",     bus.dec_pc,          32'h4);
    check("s2_target", 32'(bus.dec_target), 32'd2);
    step();
    check("s3_valid",  32'(bus.dec_valid),  32'd0);
    check("s3_target", 32'(bus.dec_target), 32'd0);

    // LSB block
    lsb_full = 1'b1;
    push_set(I_SW, 32'h8); exp_push(2'b10, 32'h8, I_SW);
    step();
    idle();
    step();
    check("lsb_blk_valid", 32'(bus.dec_valid), 32'd0);
    check("lsb_blk_why",   32'(stall_reason),  32'd3);
    check("lsb_blk_state", 32'(dbg_state),     32'd1);
    step();
    check("lsb_blk_valid2", 32'(bus.dec_valid), 32'd0);
    lsb_full = 1'b0;
    step();
    check("lsb_rel_valid",  32'(bus.dec_valid),  32'd1);
    check("lsb_rel_target", 32'(bus.dec_target), 32'd2);
    check("lsb_rel_why",    32'(stall_reason),   32'd0);
    step();

    // queue full under rob_full
    rob_full = 1'b1;
    begin
      logic [31:0] qi [5];
      logic [1:0]  qt [5];
      qi[0] = I_ADD; qi[1] = I_LUI; qi[2] = I_SW; qi[3] = I_JAL; qi[4] = I_BEQ;
      qt[0] = 2'b01; qt[1] = 2'b11; qt[2] = 2'b10; qt[3] = 2'b11; qt[4] = 2'b01;
      for (int i = 0; i < 5; i++) begin
        push_set(qi[i], 32'h10 + 32'(4 * i));
        check("full_if_ready", 32'(bus.if_ready), (i < 4) ? 32'd1 : 32'd0);
        if (i < 4) exp_push(qt[i], 32'h10 + 32'(4 * i), qi[i]);
        step();
      end
    end
    idle();
    check("full_count",    32'(dbg_count),    32'd4);
    check("full_why",      32'(stall_reason), 32'd1);
    check("full_state",    32'(dbg_state),    32'd1);
    check("full_if_ready2", 32'(bus.if_ready), 32'd0);
    rob_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("drain_valid", 32'(bus.dec_valid), 32'd1);
      check("drain_pc",    bus.dec_pc,         32'h10 + 32'(4 * i));
    end
    check("drain_if_ready", 32'(bus.if_ready), 32'd1);
    check("drain_count",    32'(dbg_count),    32'd0);
    step();

    // flush mid-stream
    rs_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_set(I_ADDI, 32'h40 + 32'(4 * i));
      step();
    end
    push_set(I_ADDI, 32'h4C);
    flush = 1'b1;
    check("pre_flush_if_ready", 32'(bus.if_ready), 32'd1);
    step();
    flush = 1'b0;
    idle();
    check("flush_count",    32'(dbg_count),     32'd0);
    check("flush_if_ready", 32'(bus.if_ready),  32'd0);
    check("flush_state",    32'(dbg_state),     32'd2);
    check("flush_valid",    32'(bus.dec_valid), 32'd0);
    check("flush_why",      32'(stall_reason),  32'd0);
    rs_full = 1'b0;
    step();
    check("post_flush_if_ready", 32'(bus.if_ready),  32'd1);
    check("post_flush_state",    32'(dbg_state),     32'd0);
    check("post_flush_valid",    32'(bus.dec_valid), 32'd0);
    push_set(I_ADDI, 32'h50); exp_push(2'b01, 32'h50, I_ADDI);
    step();
    idle();
    check("post_flush_count", 32'(dbg_count), 32'd1);
    step();
    check("post_flush_issue", 32'(bus.dec_valid), 32'd1);
    check("post_flush_pc",    bus.dec_pc,         32'h50);
    step();

    // wrap-around stream of 10
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) begin
        push_set(I_ADDI, 32'(4 * i)); exp_push(2'b01, 32'(4 * i), I_ADDI);
      end else begin
        push_set(I_LW, 32'(4 * i));   exp_push(2'b10, 32'(4 * i), I_LW);
      end
      step();
      if (i > 0) begin
        check("wrap_valid", 32'(bus.dec_valid), 32'd1);
        check("wrap_pc",    bus.dec_pc,         32'(4 * (i - 1)));
      end
    end
    idle();
    step();
    check("wrap_last_pc", bus.dec_pc, 32'h24);
    step();
    check("wrap_done_valid", 32'(bus.dec_valid), 32'd0);
    check("wrap_done_count", 32'(dbg_count),     32'd0);

    // reset mid-operation discards queued entries
    rob_full = 1'b1;
    push_set(I_ADDI, 32'h60);
    step();
    push_set(I_LW, 32'h64);
    step();
    idle();
    check("mid_rst_pre_count", 32'(dbg_count), 32'd2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    rob_full = 1'b0;
    check("mid_rst_count", 32'(dbg_count), 32'd0);
    step();
    check("mid_rst_valid", 32'(bus.dec_valid), 32'd0);
    step();

    // rdy_in low blocks enqueue
    rdy = 1'b0;
    push_set(I_ADDI, 32'h70);
    step();
    idle();
    rdy = 1'b1;
    check("frozen_count", 32'(dbg_count), 32'd0);
    step();
    check("frozen_valid", 32'(bus.dec_valid), 32'd0);

`ifdef ISSUE_PERF_EN
    // stall counter: 7 stalled edges, then 7 with 3 frozen
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("perf_zero", 32'(stall_cycles), 32'd0);
    rob_full = 1'b1;
    push_set(I_ADDI, 32'h80); exp_push(2'b01, 32'h80, I_ADDI);
    step();
    idle();
    repeat (7) step();
    check("perf_7", 32'(stall_cycles), 32'd7);
    rob_full = 1'b0;
    step();
    check("perf_issue_pc", bus.dec_pc,          32'h80);
    check("perf_hold",     32'(stall_cycles),   32'd7);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("perf_zero2", 32'(stall_cycles), 32'd0);
    rob_full = 1'b1;
    push_set(I_ADDI, 32'h84); exp_push(2'b01, 32'h84, I_ADDI);
    step();
    idle();
    for (int i = 0; i < 7; i++) begin
      rdy = !(i >= 2 && i <= 4);
      step();
    end
    rdy = 1'b1;
    check("perf_4", 32'(stall_cycles), 32'd4);
    rob_full = 1'b0;
    step();
    check("perf_issue_pc2", bus.dec_pc, 32'h84);
    step();
`endif

    step();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
